// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle MIPS-subset core with req/ack instruction and data memory ports
// One shared ALU, one FSM; memories may stall through their ack inputs.
module multicycle_cpu #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                REG_NUM  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  input  logic              imem_ack_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic              retire_o,
  output logic              halt_o,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int                RW        = $clog2(REG_NUM);
  localparam logic [31:0]       REG_NUM_U = REG_NUM;
  localparam logic [ADDR_W-1:0] J_KEEP    = ~ADDR_W'(28'hFFF_FFFF);

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [DATA_W-1:0] regs_q [REG_NUM];

  logic              rf_we;
  logic [RW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              retire;

  function automatic logic [RW-1:0] ridx(input logic [4:0] f);
    return RW'({27'd0, f} % REG_NUM_U);
  endfunction

  logic [5:0]        op, funct;
  logic [RW-1:0]     rs_idx, rt_idx, rd_idx;
  logic signed [15:0] imm_s;
  logic [DATA_W-1:0] imm_ext, rs_val, rt_val, alu_b, alu_res;
  logic [ADDR_W-1:0] br_tgt, j_tgt;
  logic              legal;

  assign op      = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign rs_idx  = ridx(ir_q[25:21]);
  assign rt_idx  = ridx(ir_q[20:16]);
  assign rd_idx  = ridx(ir_q[15:11]);
  assign imm_s   = ir_q[15:0];
  assign imm_ext = DATA_W'(imm_s);
  assign rs_val  = (rs_idx == '0) ? '0 : regs_q[rs_idx];
  assign rt_val  = (rt_idx == '0) ? '0 : regs_q[rt_idx];
  // pc_q already holds PC+4 by the time branches and jumps resolve
  assign br_tgt  = pc_q + (ADDR_W'(imm_s) << 2);
  assign j_tgt   = (pc_q & J_KEEP) | ADDR_W'({ir_q[25:0], 2'b00});

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R:    legal = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                       (funct == F_OR)  || (funct == F_SLT);
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_HALT: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_b   = (op == OP_R) ? b_q : imm_ext;
    alu_res = a_q + alu_b;
    if (op == OP_R) begin
      case (funct)
        F_SUB:   alu_res = a_q - alu_b;
        F_AND:   alu_res = a_q & alu_b;
        F_OR:    alu_res = a_q | alu_b;
        F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(alu_b)};
        default: alu_res = a_q + alu_b;
      endcase
    end else if (op == OP_SLTI) begin
      alu_res = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(alu_b)};
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = rd_idx;
    rf_wdata = alu_q;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: if (imem_ack_i) begin
        ir_d    = imem_rdata_i;
        pc_d    = pc_q + ADDR_W'(4);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = rs_val;
        b_d = rt_val;
        if (!legal) begin
          state_d = S_HALT;
        end else if (op == OP_HALT) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = alu_res;
        case (op)
          OP_R, OP_ADDI, OP_SLTI: state_d = S_WB;
          OP_LW, OP_SW:           state_d = S_MEM;
          OP_BEQ, OP_BNE: begin
            if ((a_q == b_q) == (op == OP_BEQ)) pc_d = br_tgt;
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          OP_J: begin
            pc_d    = j_tgt;
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: if (dmem_ack_i) begin
        if (op == OP_LW) begin
          mdr_d   = dmem_rdata_i;
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (op == OP_R) ? rd_idx : rt_idx;
        rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (rf_we && rf_waddr != '0) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Requests and retire are masked during reset so an aborted instruction leaves no trace
  assign imem_req_o   = (state_q == S_FETCH) && !rst_i;
  assign imem_addr_o  = pc_q;
  assign dmem_req_o   = (state_q == S_MEM) && !rst_i;
  assign dmem_we_o    = dmem_req_o && (op == OP_SW);
  assign dmem_addr_o  = ADDR_W'(alu_q);
  assign dmem_wdata_o = b_q;
  assign retire_o     = retire && !rst_i;
  assign halt_o       = (state_q == S_HALT);
  assign pc_o         = pc_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - directed vector bench for multicycle_cpu
// Programs run from a table of {addr, instr, dmem wait, latency, reg, value, next pc} records.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o, imem_ack_i, dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [31:0] imem_addr_o, imem_rdata_i, dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic        retire_o, halt_o;
  logic [31:0] pc_o;

  always #5 clk = ~clk;

  multicycle_cpu dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i), .imem_ack_i(imem_ack_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .retire_o(retire_o), .halt_o(halt_o), .pc_o(pc_o)
  );

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int          dwait = 0, dcnt = 0, stable_err = 0;
  logic        stray = 1'b0;
  logic [31:0] d_addr_l, d_wdata_l;
  logic        d_we_l;

  assign imem_ack_i   = imem_req_o;
  assign imem_rdata_i = imem[imem_addr_o[7:2]];
  assign dmem_ack_i   = (dmem_req_o && dcnt >= dwait) || stray;
  assign dmem_rdata_i = dmem[dmem_addr_o[7:2]];

  // Data memory: stalls dwait cycles, and tracks request stability while waiting
  always @(posedge clk) begin
    if (dmem_req_o) begin
      if (dcnt == 0) begin
        d_addr_l  <= dmem_addr_o;
        d_wdata_l <= dmem_wdata_o;
        d_we_l    <= dmem_we_o;
      end else if (dmem_addr_o !== d_addr_l || dmem_wdata_o !== d_wdata_l || dmem_we_o !== d_we_l) begin
        stable_err <= stable_err + 1;
      end
      if (dmem_ack_i && dmem_we_o) dmem[dmem_addr_o[7:2]] <= dmem_wdata_o;
    end
    dcnt <= (dmem_req_o && !dmem_ack_i) ? dcnt + 1 : 0;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          dw;
    int          lat;
    int          rg;
    logic [31:0] rval;
    logic [31:0] npc;
  } vec_t;

  vec_t tv [19];
  int   n_app = 0, n_err = 0;
  int   cnt, rets;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_app++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
  endtask

  task automatic wait_retire(inout int c);
    while (!retire_o && c < 200) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    tv[0]  = '{32'h00, 32'h20010005, 0, 4,  1, 32'd5,          32'h04}; // addi $1,$0,5
    tv[1]  = '{32'h04, 32'h2002FFFD, 0, 4,  2, 32'hFFFF_FFFD,  32'h08}; // addi $2,$0,-3
    tv[2]  = '{32'h08, 32'h00221820, 0, 4,  3, 32'd2,          32'h0C}; // add $3,$1,$2
    tv[3]  = '{32'h0C, 32'h0041202A, 0, 4,  4, 32'd1,          32'h10}; // slt $4,$2,$1
    tv[4]  = '{32'h10, 32'h00223822, 0, 4,  7, 32'd8,          32'h14}; // sub $7,$1,$2
    tv[5]  = '{32'h14, 32'h00224025, 0, 4,  8, 32'hFFFF_FFFD,  32'h18}; // or $8,$1,$2
    tv[6]  = '{32'h18, 32'h00614824, 0, 4,  9, 32'd0,          32'h1C}; // and $9,$3,$1
    tv[7]  = '{32'h1C, 32'h284A0000, 0, 4, 10, 32'd1,          32'h20}; // slti $10,$2,0
    tv[8]  = '{32'h20, 32'h282BFFFF, 0, 4, 11, 32'd0,          32'h24}; // slti $11,$1,-1
    tv[9]  = '{32'h24, 32'h20000007, 0, 4,  0, 32'd0,          32'h28}; // addi $0,$0,7
    tv[10] = '{32'h28, 32'h0022602A, 0, 4, 12, 32'd0,          32'h2C}; // slt $12,$1,$2
    tv[11] = '{32'h2C, 32'hAC030008, 3, 7,  3, 32'd2,          32'h30}; // sw $3,8($0)
    tv[12] = '{32'h30, 32'h8C050008, 3, 8,  5, 32'd2,          32'h34}; // lw $5,8($0)
    tv[13] = '{32'h34, 32'h14000010, 0, 3,  5, 32'd2,          32'h38}; // bne $0,$0 not taken
    tv[14] = '{32'h38, 32'h10230004, 0, 3,  1, 32'd5,          32'h3C}; // beq $1,$3 not taken
    tv[15] = '{32'h3C, 32'h14230002, 0, 3,  1, 32'd5,          32'h48}; // bne $1,$3,+2 taken
    tv[16] = '{32'h48, 32'h08000014, 0, 3,  1, 32'd5,          32'h50}; // j 0x50
    tv[17] = '{32'h50, 32'h1000FFFF, 0, 3,  1, 32'd5,          32'h50}; // beq $0,$0,-1
    tv[18] = '{32'h50, 32'h1000FFFF, 0, 3,  1, 32'd5,          32'h50}; // loops again

    foreach (imem[i]) imem[i] = 32'h0;
    foreach (dmem[i]) dmem[i] = 32'h0;
    foreach (tv[i]) imem[tv[i].addr[7:2]] = tv[i].instr;

    // Reset state
    do_reset();
    check("rst_pc", pc_o, 32'h0);
    check("rst_imem_req", {31'd0, imem_req_o}, 32'd1);
    check("rst_halt", {31'd0, halt_o}, 32'd0);
    check("rst_retire", {31'd0, retire_o}, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req_o}, 32'd0);

    cnt = 1;
    for (int i = 0; i < 19; i++) begin
      dwait = tv[i].dw;
      check("fetch_addr", imem_addr_o, tv[i].addr);
      wait_retire(cnt);
      check($sformatf("latency[%0d]", i), 32'(cnt), 32'(tv[i].lat));
      @(negedge clk);
      cnt = 1;
      check($sformatf("next_pc[%0d]", i), pc_o, tv[i].npc);
      check($sformatf("reg[%0d]", i), dut.regs_q[tv[i].rg], tv[i].rval);
      if (i == 12) begin
        check("mem8", dmem[2], 32'd2);
        check("req_stable", 32'(stable_err), 32'd0);
      end
    end
    dwait = 0;

    // halt op retires in two cycles, then freezes
    imem[0] = 32'hFC000000;
    do_reset();
    cnt = 1;
    wait_retire(cnt);
    check("halt_op_latency", 32'(cnt), 32'd2);
    @(negedge clk);
    check("halt_op_halt", {31'd0, halt_o}, 32'd1);
    check("halt_op_pc", pc_o, 32'h4);

    // illegal op stops without retiring
    imem[0] = 32'hF8000000;
    do_reset();
    rets = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (retire_o) rets++;
    end
    check("illegal_retires", 32'(rets), 32'd0);
    check("illegal_halt", {31'd0, halt_o}, 32'd1);
    check("illegal_imem_req", {31'd0, imem_req_o}, 32'd0);
    check("illegal_pc", pc_o, 32'h4);
    do_reset();
    check("resume_req", {31'd0, imem_req_o}, 32'd1);
    check("resume_pc", pc_o, 32'h0);
    check("resume_halt", {31'd0, halt_o}, 32'd0);

    // reset during a stalled lw, stray ack afterwards
    imem[0] = 32'h8C060008;
    dwait   = 20;
    do_reset();
    cnt = 1;
    while (!dmem_req_o && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("lw_mem_cycle", 32'(cnt), 32'd4);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    stray = 1'b1;
    #1;
    check("abort_fetch_addr", imem_addr_o, 32'h0);
    check("abort_imem_req", {31'd0, imem_req_o}, 32'd1);
    rets = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (retire_o) rets++;
    end
    stray = 1'b0;
    check("abort_retires", 32'(rets), 32'd0);
    check("abort_reg6", dut.regs_q[6], 32'd0);
    check("abort_exec_no_req", {31'd0, dmem_req_o}, 32'd0);
    @(negedge clk);
    check("abort_mem_req", {31'd0, dmem_req_o}, 32'd1);
    check("abort_pc", pc_o, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_err);
    $finish;
  end

endmodule
